// File: rtl/mii_frame_receiver.sv
// MII loopback receiver: strips preamble/SFD, recovers 14-bit samples from the payload and reports
// per-frame length/FCS status with saturating counters. Define MII_RX_CRC_CHECK_EN to include the FCS check.
module mii_frame_receiver #(
    parameter int HDR_BYTES       = 14,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int CNT_W           = 16
) (
    input  logic             rd_clk,
    input  logic             rst_n,
    input  logic [3:0]       mii_rxd,
    input  logic             mii_rx_dv,
    output logic [13:0]      sample_data,
    output logic             sample_valid,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             len_err,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count,
    output logic [2:0]       rx_state
);

    localparam int BC_W = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [BC_W-1:0] MIN_BYTES = BC_W'(HDR_BYTES + 4);
    localparam logic [BC_W-1:0] MAX_BYTES = BC_W'(MAX_FRAME_BYTES);
    localparam logic [BC_W-1:0] HDR_LAST  = BC_W'(HDR_BYTES - 1);
    localparam logic [BC_W-1:0] FOUR      = BC_W'(4);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_DROP     = 3'd4
    } state_t;

    state_t            state_reg;
    logic              armed_reg;
    logic              sfd_seen_reg;
    logic              nib_phase_reg;
    logic              pay_half_reg;
    logic              oversize_reg;
    logic [3:0]        lo_nib_reg;
    logic [5:0]        msb_reg;
    logic [BC_W-1:0]   byte_cnt_reg;
    logic [13:0]       sample_data_reg;
    logic              sample_valid_reg;
    logic              frame_done_reg;
    logic              frame_ok_reg;
    logic              len_err_reg;
    logic [CNT_W-1:0]  frame_count_reg;
    logic [CNT_W-1:0]  err_count_reg;
    logic [7:0]        line_reg [4];
    logic [7:0]        line_in  [4];

    logic              in_frame;
    logic              byte_done;
    logic [7:0]        new_byte;
    logic              over_hit;
    logic              pop_en;
    logic [BC_W-1:0]   pop_idx;
    logic              sfd_hit;
    logic              end_frame;
    logic              short_frame;
    logic              odd_payload;
    logic              len_bad;
    logic              crc_good;
    logic              frame_good;

    assign in_frame    = (state_reg == S_HEADER) || (state_reg == S_PAYLOAD);
    assign byte_done   = in_frame && mii_rx_dv && nib_phase_reg;
    assign new_byte    = {mii_rxd, lo_nib_reg};
    assign over_hit    = byte_done && (byte_cnt_reg == MAX_BYTES);
    // The byte leaving the delay line is the one pushed four bytes earlier.
    assign pop_en      = byte_done && !over_hit && (byte_cnt_reg >= FOUR);
    assign pop_idx     = byte_cnt_reg - FOUR;
    assign sfd_hit     = (state_reg == S_PREAMBLE) && mii_rx_dv && (mii_rxd == 4'hD);
    assign end_frame   = !mii_rx_dv && (in_frame || ((state_reg == S_DROP) && sfd_seen_reg));
    assign short_frame = byte_cnt_reg < MIN_BYTES;
    assign odd_payload = !short_frame && (byte_cnt_reg[0] != MIN_BYTES[0]);
    assign len_bad     = nib_phase_reg || short_frame || odd_payload || oversize_reg;
    assign frame_good  = !len_bad && crc_good;

`ifdef MII_RX_CRC_CHECK_EN
    logic [31:0] crc_reg;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= '0;
        end else if (sfd_hit) begin
            crc_reg <= '1;
        end else if (byte_done) begin
            crc_reg <= crc32_byte(crc_reg, new_byte);
        end
    end

    // Running the FCS through the CRC leaves this fixed residue on an intact frame.
    assign crc_good = (crc_reg == 32'hDEBB_20E3);
`else
    assign crc_good = 1'b1;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                assign line_in[gi] = new_byte;
            end else begin : g_tail
                assign line_in[gi] = line_reg[gi-1];
            end
            always_ff @(posedge rd_clk or negedge rst_n) begin
                if (!rst_n) begin
                    line_reg[gi] <= '0;
                end else if (byte_done) begin
                    line_reg[gi] <= line_in[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            armed_reg        <= 1'b0;
            sfd_seen_reg     <= 1'b0;
            nib_phase_reg    <= 1'b0;
            pay_half_reg     <= 1'b0;
            oversize_reg     <= 1'b0;
            lo_nib_reg       <= '0;
            msb_reg          <= '0;
            byte_cnt_reg     <= '0;
            sample_data_reg  <= '0;
            sample_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            frame_ok_reg     <= 1'b0;
            len_err_reg      <= 1'b0;
            frame_count_reg  <= '0;
            err_count_reg    <= '0;
        end else begin
            sample_valid_reg <= 1'b0;
            frame_done_reg   <= 1'b0;
            // After reset the receiver must see an idle line before trusting the next preamble.
            if (!mii_rx_dv) begin
                armed_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (mii_rx_dv && armed_reg) begin
                        sfd_seen_reg <= 1'b0;
                        state_reg    <= (mii_rxd == 4'h5) ? S_PREAMBLE : S_DROP;
                    end
                end
                S_PREAMBLE: begin
                    if (!mii_rx_dv) begin
                        state_reg <= S_IDLE;
                    end else if (sfd_hit) begin
                        state_reg     <= S_HEADER;
                        sfd_seen_reg  <= 1'b1;
                        byte_cnt_reg  <= '0;
                        nib_phase_reg <= 1'b0;
                        pay_half_reg  <= 1'b0;
                        oversize_reg  <= 1'b0;
                    end else if (mii_rxd != 4'h5) begin
                        state_reg <= S_DROP;
                    end
                end
                S_HEADER, S_PAYLOAD: begin
                    if (!mii_rx_dv) begin
                        state_reg <= S_IDLE;
                    end else if (!nib_phase_reg) begin
                        lo_nib_reg    <= mii_rxd;
                        nib_phase_reg <= 1'b1;
                    end else begin
                        nib_phase_reg <= 1'b0;
                        if (over_hit) begin
                            oversize_reg <= 1'b1;
                            state_reg    <= S_DROP;
                        end else begin
                            byte_cnt_reg <= byte_cnt_reg + BC_W'(1);
                            if (pop_en) begin
                                if (state_reg == S_HEADER) begin
                                    if (pop_idx == HDR_LAST) begin
                                        state_reg    <= S_PAYLOAD;
                                        pay_half_reg <= 1'b0;
                                    end
                                end else if (!pay_half_reg) begin
                                    msb_reg      <= line_reg[3][5:0];
                                    pay_half_reg <= 1'b1;
                                end else begin
                                    sample_data_reg  <= {msb_reg, line_reg[3]};
                                    sample_valid_reg <= 1'b1;
                                    pay_half_reg     <= 1'b0;
                                end
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (!mii_rx_dv) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase

            if (end_frame) begin
                frame_done_reg <= 1'b1;
                len_err_reg    <= len_bad;
                frame_ok_reg   <= frame_good;
                if (frame_good) begin
                    if (frame_count_reg != '1) begin
                        frame_count_reg <= frame_count_reg + CNT_W'(1);
                    end
                end else if (err_count_reg != '1) begin
                    err_count_reg <= err_count_reg + CNT_W'(1);
                end
            end
        end
    end

    assign sample_data  = sample_data_reg;
    assign sample_valid = sample_valid_reg;
    assign frame_done   = frame_done_reg;
    assign frame_ok     = frame_ok_reg;
    assign len_err      = len_err_reg;
    assign frame_count  = frame_count_reg;
    assign err_count    = err_count_reg;
    assign rx_state     = state_reg;

endmodule

// File: tb/tb_mii_frame_receiver.sv
// Bench for mii_frame_receiver: directed and random frames compared against a frame-level model
// (samples, status, counters with CNT_W=4). FCS expectations follow MII_RX_CRC_CHECK_EN.
module tb_mii_frame_receiver;

    localparam int HDR  = 14;
    localparam int MAXB = 1518;
    localparam int CW   = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic          rd_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    mii_rxd = 4'h0;
    logic          mii_rx_dv = 1'b0;
    logic [13:0]   sample_data;
    logic          sample_valid;
    logic          frame_done;
    logic          frame_ok;
    logic          len_err;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] err_count;
    logic [2:0]    rx_state;

    mii_frame_receiver #(.HDR_BYTES(HDR), .MAX_FRAME_BYTES(MAXB), .CNT_W(CW)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv),
        .sample_data(sample_data), .sample_valid(sample_valid), .frame_done(frame_done),
        .frame_ok(frame_ok), .len_err(len_err), .frame_count(frame_count),
        .err_count(err_count), .rx_state(rx_state)
    );

    always #5 rd_clk = ~rd_clk;

    int cyc = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    logic [13:0] got_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_sv_cyc = -1;
    logic        last_ok = 1'b0;
    logic        last_len = 1'b0;

    always @(negedge rd_clk) begin
        if (sample_valid) begin
            got_q.push_back(sample_data);
            if (first_sv_cyc < 0) first_sv_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
            last_ok  = frame_ok;
            last_len = len_err;
        end
    end

    int          n_checks = 0;
    int          n_pass = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  pay_q[$];
    logic [13:0] exp_q[$];
    bit          exp_ok;
    bit          exp_len;
    int          exp_fc = 0;
    int          exp_ec = 0;
    int          exp_first_cyc = -1;
    int          exp_done_cyc = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, tx_q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Header (random), payload from pay_q, FCS least significant byte first; optional single-bit corruption.
    task automatic build_frame(input bit flip);
        logic [31:0] f;
        logic [7:0]  m;
        int          idx;
        tx_q.delete();
        for (int i = 0; i < HDR; i++) tx_q.push_back(8'($urandom));
        foreach (pay_q[i]) tx_q.push_back(pay_q[i]);
        f = fcs_of(tx_q.size());
        for (int i = 0; i < 4; i++) tx_q.push_back(f[8*i +: 8]);
        if (flip) begin
            idx = (pay_q.size() > 0) ? HDR + $urandom_range(0, pay_q.size() - 1) : $urandom_range(0, HDR - 1);
            m = 8'h01 << $urandom_range(0, 7);
            tx_q[idx] = tx_q[idx] ^ m;
        end
    endtask

    task automatic random_payload(input int nbytes);
        pay_q.delete();
        for (int i = 0; i < nbytes; i++) pay_q.push_back(8'($urandom));
    endtask

    // Frame-level reference: the last four bytes are FCS, the first HDR are header, the rest pair into samples.
    task automatic predict(input bit odd_nib);
        int          n, eff, npay;
        logic [7:0]  b0, b1;
        logic [13:0] s;
        bit          crc_ok;
        n    = tx_q.size();
        eff  = (n > MAXB) ? MAXB : n;
        npay = eff - 4 - HDR;
        if (npay < 0) npay = 0;
        for (int j = 0; j < npay / 2; j++) begin
            b0 = tx_q[HDR + 2*j];
            b1 = tx_q[HDR + 2*j + 1];
            s  = {b0[5:0], b1};
            exp_q.push_back(s);
        end
        exp_len = odd_nib || (n < HDR + 4) || (n > MAXB);
        if (n >= HDR + 4 && ((n - HDR - 4) % 2) != 0) exp_len = 1'b1;
        crc_ok = 1'b0;
        if (n >= 4) crc_ok = ({tx_q[n-1], tx_q[n-2], tx_q[n-3], tx_q[n-4]} == fcs_of(n - 4));
`ifdef MII_RX_CRC_CHECK_EN
        exp_ok = !exp_len && crc_ok;
`else
        exp_ok = !exp_len;
`endif
        if (exp_ok) begin
            if (exp_fc < SAT) exp_fc++;
        end else if (exp_ec < SAT) exp_ec++;
    endtask

    task automatic drive(input logic [3:0] nib);
        @(negedge rd_clk);
        mii_rxd   = nib;
        mii_rx_dv = 1'b1;
    endtask

    task automatic send(input bit odd_nib, input bit clear);
        if (clear) begin
            got_q.delete();
            done_cnt     = 0;
            first_sv_cyc = -1;
        end
        exp_first_cyc = -1;
        repeat (15) drive(4'h5);
        drive(4'hD);
        foreach (tx_q[i]) begin
            drive(tx_q[i][3:0]);
            drive(tx_q[i][7:4]);
            if (i == HDR + 5) exp_first_cyc = cyc + 1;
        end
        if (odd_nib) drive(4'($urandom));
        @(negedge rd_clk);
        mii_rx_dv    = 1'b0;
        mii_rxd      = 4'h0;
        exp_done_cyc = cyc + 1;
    endtask

    task automatic check_frame(input string tag, input int exp_done, input bit timing);
        int n;
        repeat (3) @(negedge rd_clk);
        check({tag, " nsamples"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int j = 0; j < n; j++) check($sformatf("%s sample%0d", tag, j), got_q[j], exp_q[j]);
        if (timing && exp_q.size() > 0) check({tag, " first_sample_cycle"}, first_sv_cyc, exp_first_cyc);
        check({tag, " frame_done_count"}, done_cnt, exp_done);
        if (exp_done > 0) begin
            check({tag, " frame_done_cycle"}, done_cyc, exp_done_cyc);
            check({tag, " frame_ok"}, last_ok, exp_ok);
            check({tag, " len_err"}, last_len, exp_len);
        end
        check({tag, " frame_count"}, frame_count, exp_fc);
        check({tag, " err_count"}, err_count, exp_ec);
        $display("frame %s: bytes=%0d samples=%0d ok=%0b len_err=%0b fc=%0d ec=%0d",
                 tag, tx_q.size(), got_q.size(), last_ok, last_len, frame_count, err_count);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " sample_data"}, sample_data, 0);
        check({tag, " sample_valid"}, sample_valid, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " frame_ok"}, frame_ok, 0);
        check({tag, " len_err"}, len_err, 0);
        check({tag, " frame_count"}, frame_count, 0);
        check({tag, " err_count"}, err_count, 0);
        check({tag, " rx_state"}, rx_state, 0);
    endtask

    initial begin
        int kind;
        bit odd;
        logic [15:0] v;

        repeat (3) @(negedge rd_clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge rd_clk);

        // Reference frame: samples 0..49.
        pay_q.delete();
        for (int i = 0; i < 50; i++) begin
            v = 16'(i);
            pay_q.push_back(v[15:8]);
            pay_q.push_back(v[7:0]);
        end
        build_frame(1'b0);
        exp_q.delete(); predict(1'b0); send(1'b0, 1'b1); check_frame("ref", 1, 1'b1);
        check("ref sample_count_50", got_q.size(), 50);

        build_frame(1'b1);
        exp_q.delete(); predict(1'b0); send(1'b0, 1'b1); check_frame("bitflip", 1, 1'b1);

        random_payload(20); build_frame(1'b0);
        exp_q.delete(); predict(1'b1); send(1'b1, 1'b1); check_frame("odd_nibble", 1, 1'b1);
        random_payload(24); build_frame(1'b0);
        exp_q.delete(); predict(1'b0); send(1'b0, 1'b1); check_frame("after_odd", 1, 1'b1);

        random_payload(1600 - HDR - 4); build_frame(1'b0);
        exp_q.delete(); predict(1'b0); send(1'b0, 1'b1); check_frame("oversize", 1, 1'b1);

        // Bad preamble: dropped silently even if a later nibble pair looks like an SFD.
        got_q.delete(); done_cnt = 0;
        drive(4'h5); drive(4'h5); drive(4'h7); drive(4'h5);
        check("badpre rx_state_drop", rx_state, 4);
        drive(4'h5); drive(4'hD); repeat (6) drive(4'($urandom));
        @(negedge rd_clk); mii_rx_dv = 1'b0;
        repeat (3) @(negedge rd_clk);
        check("badpre frame_done_count", done_cnt, 0);
        check("badpre nsamples", got_q.size(), 0);
        check("badpre frame_count", frame_count, exp_fc);
        check("badpre err_count", err_count, exp_ec);
        check("badpre rx_state_idle", rx_state, 0);

        // Back-to-back frames with a single idle cycle between them.
        exp_q.delete();
        random_payload(20); build_frame(1'b0); predict(1'b0); send(1'b0, 1'b1);
        random_payload(12); build_frame(1'b0); predict(1'b0); send(1'b0, 1'b0);
        check_frame("zero_ifg", 2, 1'b0);

        // Reset mid-payload; the remainder holds a 5,5,5,5,5,D pattern that must not restart a frame.
        random_payload(30);
        pay_q[20] = 8'h55; pay_q[21] = 8'h55; pay_q[22] = 8'hD5;
        build_frame(1'b0);
        got_q.delete(); done_cnt = 0;
        repeat (15) drive(4'h5);
        drive(4'hD);
        for (int i = 0; i < HDR + 20; i++) begin
            drive(tx_q[i][3:0]); drive(tx_q[i][7:4]);
        end
        @(negedge rd_clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        got_q.delete(); done_cnt = 0; exp_fc = 0; exp_ec = 0;
        @(negedge rd_clk);
        rst_n = 1'b1;
        for (int i = HDR + 20; i < tx_q.size(); i++) begin
            drive(tx_q[i][3:0]); drive(tx_q[i][7:4]);
        end
        check("midreset rx_state_idle", rx_state, 0);
        @(negedge rd_clk); mii_rx_dv = 1'b0;
        repeat (3) @(negedge rd_clk);
        check("midreset frame_done_count", done_cnt, 0);
        check("midreset nsamples", got_q.size(), 0);
        check("midreset frame_count", frame_count, 0);
        random_payload(16); build_frame(1'b0);
        exp_q.delete(); predict(1'b0); send(1'b0, 1'b1); check_frame("post_reset", 1, 1'b1);

        // Random mix: good, corrupted, odd payload, short, with occasional trailing nibble.
        for (int f = 0; f < 10; f++) begin
            kind = $urandom_range(0, 3);
            odd  = ($urandom_range(0, 4) == 0);
            case (kind)
                0: begin random_payload(2 * $urandom_range(0, 20)); build_frame(1'b0); end
                1: begin random_payload(2 * $urandom_range(1, 20)); build_frame(1'b1); end
                2: begin random_payload(2 * $urandom_range(0, 20) + 1); build_frame(1'b0); end
                default: begin
                    tx_q.delete();
                    repeat ($urandom_range(1, HDR + 3)) tx_q.push_back(8'($urandom));
                end
            endcase
            exp_q.delete(); predict(odd); send(odd, 1'b1);
            check_frame($sformatf("rand%0d_k%0d", f, kind), 1, 1'b1);
        end

        // Twenty good frames drive frame_count into saturation.
        for (int f = 0; f < 20; f++) begin
            random_payload(2 * $urandom_range(0, 12)); build_frame(1'b0);
            exp_q.delete(); predict(1'b0); send(1'b0, 1'b1);
            check_frame($sformatf("sat%0d", f), 1, 1'b1);
        end
        check("saturated frame_count", frame_count, 4'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
